branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- ID-stage consumer of the branch comparator flags (EQUAL, NotEQUAL, IsZero, IsBiggerThanZero, IsLessThanZero).
- Decides branch outcome, computes target, and drives the PC redirect and IF/ID flush toward the fetch stage.
- Holds the pipeline while branch operands are still in flight (forwarding not yet resolved).
- Sits between the comparator/hazard unit in ID and the PC mux in IF.

Parameters:
- ADDR_W, 32, PC and target width.
- WAIT_LIMIT, 15, maximum consecutive operand-wait cycles before br_timeout sets.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- br_valid  in  1  instruction in ID is a branch.
- br_type  in  3  0=BEQ, 1=BNE, 2=BGTZ, 3=BLEZ, 4=BLTZ, 5=BGEZ; 6–7 reserved (never taken).
- equal, not_equal, is_zero, gt_zero, lt_zero  in  1 each  comparator flags, valid when opnd_ready=1.
- opnd_ready  in  1  comparator operands are final.
- ext_stall  in  1  stall from another hazard source.
- pc_plus4  in  ADDR_W  PC+4 of the branch.
- imm_off  in  ADDR_W  sign-extended word offset.
- pc_src  out  1  registered; select br_target at the PC mux.
- br_target  out  ADDR_W  registered redirect address.
- if_id_flush  out  1  registered; squash IF/ID.
- id_stall  out  1  combinational; hold PC and IF/ID.
- br_timeout  out  1  sticky error flag.
- stat_branches, stat_taken, stat_stall_cyc  out  32 each  statistics (see Optional Feature).

Behaviour:
- Reset: state=IDLE; pc_src=0, br_target=0, if_id_flush=0, br_timeout=0, wait counter=0, stats=0. All registers reset asynchronously.
- Taken rule:
  - BEQ: equal. BNE: not_equal. BGTZ: gt_zero. BLEZ: is_zero|lt_zero. BLTZ: lt_zero. BGEZ: !lt_zero. Reserved codes: 0.
- Target: pc_plus4 + {imm_off[ADDR_W-3:0],2'b00}, modulo 2^ADDR_W; wrap-around is silent.
- FSM states: IDLE, WAIT, REDIRECT.
- IDLE:
  - ext_stall=1: hold; no evaluation.
  - br_valid & !opnd_ready: go to WAIT; id_stall=1 in the same cycle.
  - br_valid & opnd_ready & taken: go to REDIRECT; pc_src, if_id_flush and br_target are registered at this edge.
  - br_valid & opnd_ready & !taken: stay in IDLE; no outputs change.
- WAIT:
  - id_stall=1 every cycle; wait counter increments.
  - When opnd_ready=1 (and ext_stall=0), evaluate exactly as in IDLE and clear the counter. id_stall is 0 in that cycle.
  - When the counter reaches WAIT_LIMIT, set br_timeout. Keep waiting.
  - ext_stall=1: hold state and counter.
- REDIRECT:
  - Lasts exactly one cycle; pc_src=1 and if_id_flush=1 throughout.
  - br_valid is ignored (that ID instruction is being squashed). ext_stall does not extend it.
  - Next state: IDLE, with pc_src and if_id_flush returning to 0.
- Latency: redirect is visible on the cycle after the resolving edge. Taken-branch penalty is 1 bubble.
- br_target holds its last value when pc_src=0.
- br_timeout clears only on reset.
- Reset asserted mid-WAIT or mid-REDIRECT: outputs clear immediately (asynchronously); no redirect is issued after release.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined:
  - stat_branches counts resolved branches.
  - stat_taken counts taken branches.
  - stat_stall_cyc counts WAIT cycles.
  - All three saturate at 0xFFFFFFFF.
- Undefined: the stat ports remain present and are tied to 0; no counter flops are built.

Decomposition:
- Package branch_pkg:
  - br_type encoding constants (BR_BEQ..BR_BGEZ).
  - State enum (ST_IDLE, ST_WAIT, ST_REDIRECT).
  - ADDR_W default.
- One sub-module, branch_cond_eval: combinational br_type + flags → taken. Shared with any future predictor-check logic.

Test Plan:
- Reset, then BEQ (equal=1, opnd_ready=1, pc_plus4=0x0040_0004, imm_off=0x0000_0003) → next cycle: pc_src=1, if_id_flush=1, br_target=0x0040_0010; following cycle both flags are 0.
- BNE with not_equal=0 → no redirect; pc_src stays 0; id_stall never asserts.
- BGTZ with opnd_ready low for 3 cycles, then high with gt_zero=1 → id_stall=1 for exactly 3 cycles; redirect on the next cycle; stat_stall_cyc=3 when BRANCH_STATS_EN is defined.
- Negative offset imm_off=0xFFFF_FFFF, pc_plus4=0x0000_0000 → br_target=0xFFFF_FFFC (wrap-around).
- opnd_ready held low for 16 cycles → br_timeout=1 and stays 1 after resolution; only rst_n=0 clears it.
- rst_n pulsed low during the REDIRECT cycle → pc_src and if_id_flush drop immediately; state=IDLE after release; br_valid asserted during REDIRECT does not cause a second redirect.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared constants and types for the ID-stage branch resolve logic.
package branch_pkg;

    localparam int unsigned ADDR_W_DEF = 32;

    localparam logic [2:0] BR_BEQ  = 3'd0;
    localparam logic [2:0] BR_BNE  = 3'd1;
    localparam logic [2:0] BR_BGTZ = 3'd2;
    localparam logic [2:0] BR_BLEZ = 3'd3;
    localparam logic [2:0] BR_BLTZ = 3'd4;
    localparam logic [2:0] BR_BGEZ = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_REDIRECT
    } state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Maps branch type plus comparator flags to a taken decision; reserved types never take.
module branch_cond_eval
    import branch_pkg::*;
(
    input  logic [2:0] br_type_i,
    input  logic       equal_i,
    input  logic       not_equal_i,
    input  logic       is_zero_i,
    input  logic       gt_zero_i,
    input  logic       lt_zero_i,
    output logic       taken_o
);

    always_comb begin
        taken_o = 1'b0;
        case (br_type_i)
            BR_BEQ:  taken_o = equal_i;
            BR_BNE:  taken_o = not_equal_i;
            BR_BGTZ: taken_o = gt_zero_i;
            BR_BLEZ: taken_o = is_zero_i | lt_zero_i;
            BR_BLTZ: taken_o = lt_zero_i;
            BR_BGEZ: taken_o = ~lt_zero_i;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves ID-stage branches, stalls on unresolved operands and issues a one-cycle redirect.
// Optional statistics counters are built only when BRANCH_STATS_EN is defined.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              br_valid_i,
    input  logic [2:0]        br_type_i,
    input  logic              equal_i,
    input  logic              not_equal_i,
    input  logic              is_zero_i,
    input  logic              gt_zero_i,
    input  logic              lt_zero_i,
    input  logic              opnd_ready_i,
    input  logic              ext_stall_i,
    input  logic [ADDR_W-1:0] pc_plus4_i,
    input  logic [ADDR_W-1:0] imm_off_i,
    output logic              pc_src_o,
    output logic [ADDR_W-1:0] br_target_o,
    output logic              if_id_flush_o,
    output logic              id_stall_o,
    output logic              br_timeout_o,
    output logic [31:0]       stat_branches_o,
    output logic [31:0]       stat_taken_o,
    output logic [31:0]       stat_stall_cyc_o
);

    localparam int unsigned     CntW    = $clog2(WAIT_LIMIT + 1);
    localparam logic [CntW-1:0] WaitMax = CntW'(WAIT_LIMIT);

    state_e            state_q, state_d;
    logic [CntW-1:0]   wait_cnt_q, wait_cnt_d;
    logic              pc_src_q, pc_src_d;
    logic              flush_q, flush_d;
    logic              timeout_q, timeout_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic [ADDR_W-1:0] target_calc;
    logic              taken;
    logic              resolve;

    branch_cond_eval u_cond_eval (
        .br_type_i   (br_type_i),
        .equal_i     (equal_i),
        .not_equal_i (not_equal_i),
        .is_zero_i   (is_zero_i),
        .gt_zero_i   (gt_zero_i),
        .lt_zero_i   (lt_zero_i),
        .taken_o     (taken)
    );

    // Word offset scaled to bytes; overflow wraps silently.
    assign target_calc = pc_plus4_i + (imm_off_i << 2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            pc_src_q   <= 1'b0;
            flush_q    <= 1'b0;
            timeout_q  <= 1'b0;
            target_q   <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            pc_src_q   <= pc_src_d;
            flush_q    <= flush_d;
            timeout_q  <= timeout_d;
            target_q   <= target_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        resolve    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (br_valid_i && !ext_stall_i) begin
                    if (opnd_ready_i) resolve = 1'b1;
                    else              state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!ext_stall_i) begin
                    if (opnd_ready_i) begin
                        resolve    = 1'b1;
                        wait_cnt_d = '0;
                    end else begin
                        if (wait_cnt_q != WaitMax) wait_cnt_d = wait_cnt_q + 1'b1;
                        if (wait_cnt_d == WaitMax) timeout_d = 1'b1;
                    end
                end
            end
            ST_REDIRECT: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
        if (resolve) state_d = taken ? ST_REDIRECT : ST_IDLE;
    end

    always_comb begin
        id_stall_o = 1'b0;
        pc_src_d   = 1'b0;
        flush_d    = 1'b0;
        target_d   = target_q;
        unique case (state_q)
            ST_IDLE: id_stall_o = br_valid_i && !ext_stall_i && !opnd_ready_i;
            ST_WAIT: id_stall_o = !(opnd_ready_i && !ext_stall_i);
            default: id_stall_o = 1'b0;
        endcase
        if (resolve && taken) begin
            pc_src_d = 1'b1;
            flush_d  = 1'b1;
            target_d = target_calc;
        end
    end

    assign pc_src_o      = pc_src_q;
    assign if_id_flush_o = flush_q;
    assign br_target_o   = target_q;
    assign br_timeout_o  = timeout_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] br_cnt_q, taken_cnt_q, stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q    <= '0;
            taken_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (resolve && br_cnt_q != '1) br_cnt_q <= br_cnt_q + 32'd1;
            if (resolve && taken && taken_cnt_q != '1) taken_cnt_q <= taken_cnt_q + 32'd1;
            if (state_q == ST_WAIT && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stat_branches_o  = br_cnt_q;
    assign stat_taken_o     = taken_cnt_q;
    assign stat_stall_cyc_o = stall_cnt_q;
`else
    assign stat_branches_o  = '0;
    assign stat_taken_o     = '0;
    assign stat_stall_cyc_o = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboarded bench for branch_resolve_unit: redirect targets are queued at stimulus time
// and consumed by a monitor whenever pc_src is seen high.
module tb_branch_resolve_unit;
    import branch_pkg::*;

    localparam int unsigned AW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          br_valid, equal, not_equal, is_zero, gt_zero, lt_zero;
    logic          opnd_ready, ext_stall;
    logic [2:0]    br_type;
    logic [AW-1:0] pc_plus4, imm_off;
    logic          pc_src, if_id_flush, id_stall, br_timeout;
    logic [AW-1:0] br_target;
    logic [31:0]   stat_branches, stat_taken, stat_stall_cyc;

    int            n_checks = 0;
    int            n_pass = 0;
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] exp_t;

    // {br_type, equal, not_equal, is_zero, gt_zero, lt_zero, taken}
    localparam logic [8:0] COND_TBL [15] = '{
        {3'd1, 5'b10000, 1'b0}, {3'd0, 5'b01000, 1'b0}, {3'd5, 5'b01001, 1'b0},
        {3'd3, 5'b01010, 1'b0}, {3'd4, 5'b01010, 1'b0}, {3'd2, 5'b10100, 1'b0},
        {3'd6, 5'b11111, 1'b0}, {3'd7, 5'b11111, 1'b0}, {3'd1, 5'b01010, 1'b1},
        {3'd3, 5'b10100, 1'b1}, {3'd3, 5'b01001, 1'b1}, {3'd4, 5'b01001, 1'b1},
        {3'd5, 5'b01010, 1'b1}, {3'd5, 5'b10100, 1'b1}, {3'd2, 5'b01010, 1'b1}
    };

    branch_resolve_unit #(.ADDR_W(AW), .WAIT_LIMIT(15)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .br_valid_i       (br_valid),
        .br_type_i        (br_type),
        .equal_i          (equal),
        .not_equal_i      (not_equal),
        .is_zero_i        (is_zero),
        .gt_zero_i        (gt_zero),
        .lt_zero_i        (lt_zero),
        .opnd_ready_i     (opnd_ready),
        .ext_stall_i      (ext_stall),
        .pc_plus4_i       (pc_plus4),
        .imm_off_i        (imm_off),
        .pc_src_o         (pc_src),
        .br_target_o      (br_target),
        .if_id_flush_o    (if_id_flush),
        .id_stall_o       (id_stall),
        .br_timeout_o     (br_timeout),
        .stat_branches_o  (stat_branches),
        .stat_taken_o     (stat_taken),
        .stat_stall_cyc_o (stat_stall_cyc)
    );

    always #5 clk = ~clk;

    // Every observed redirect must match the oldest queued target.
    always @(negedge clk) begin
        if (rst_n && pc_src) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_redirect: got pc_src=1 target=%h, want no redirect",
                         br_target);
            end else begin
                exp_t = exp_q.pop_front();
                if (br_target !== exp_t)
                    $display("FAIL redirect_target: got %h want %h", br_target, exp_t);
                else n_pass++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        br_valid = 1'b0; br_type = BR_BEQ;
        equal = 1'b0; not_equal = 1'b0; is_zero = 1'b0; gt_zero = 1'b0; lt_zero = 1'b0;
        opnd_ready = 1'b1; ext_stall = 1'b0;
        pc_plus4 = '0; imm_off = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({pc_src, if_id_flush, br_timeout, id_stall} !== 4'b0000)
            $display("FAIL reset_flags: got %b want 0000", {pc_src, if_id_flush, br_timeout, id_stall});
        else n_pass++;
        n_checks++;
        if (br_target !== '0) $display("FAIL reset_target: got %h want 0", br_target);
        else n_pass++;
        n_checks++;
        if ({stat_branches, stat_taken, stat_stall_cyc} !== 96'd0)
            $display("FAIL reset_stats: got %h %h %h want 0", stat_branches, stat_taken, stat_stall_cyc);
        else n_pass++;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_beq();
        br_valid = 1'b1; br_type = BR_BEQ; equal = 1'b1; opnd_ready = 1'b1;
        pc_plus4 = 32'h0040_0004; imm_off = 32'h0000_0003;
        #1;
        n_checks++;
        if (id_stall !== 1'b0) $display("FAIL beq_stall: got %b want 0", id_stall);
        else n_pass++;
        exp_q.push_back(32'h0040_0010);
        tick();
        idle_inputs();
        n_checks++;
        if ({pc_src, if_id_flush} !== 2'b11)
            $display("FAIL beq_redirect: got %b want 11", {pc_src, if_id_flush});
        else n_pass++;
        tick();
        n_checks++;
        if ({pc_src, if_id_flush} !== 2'b00)
            $display("FAIL beq_release: got %b want 00", {pc_src, if_id_flush});
        else n_pass++;
        n_checks++;
        if (br_target !== 32'h0040_0010)
            $display("FAIL beq_target_hold: got %h want 00400010", br_target);
        else n_pass++;
    endtask

    task automatic test_conditions();
        logic [8:0]    row;
        logic [AW-1:0] pc, imm;
        for (int i = 0; i < 15; i++) begin
            row = COND_TBL[i];
            pc  = 32'h0000_1000 + 32'(i) * 32'h100;
            imm = 32'(i) - 32'd4;
            br_valid = 1'b1; br_type = row[8:6];
            equal = row[5]; not_equal = row[4]; is_zero = row[3]; gt_zero = row[2];
            lt_zero = row[1]; opnd_ready = 1'b1; pc_plus4 = pc; imm_off = imm;
            #1;
            n_checks++;
            if (id_stall !== 1'b0) $display("FAIL cond_stall[%0d]: got %b want 0", i, id_stall);
            else n_pass++;
            if (row[0]) exp_q.push_back(pc + {imm[AW-3:0], 2'b00});
            tick();
            idle_inputs();
            n_checks++;
            if (pc_src !== row[0])
                $display("FAIL cond_taken[%0d] type=%0d: got %b want %b", i, row[8:6], pc_src, row[0]);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_stall();
        int stalls = 0;
        do_reset();
        br_valid = 1'b1; br_type = BR_BGTZ; opnd_ready = 1'b0; gt_zero = 1'b0;
        pc_plus4 = 32'h0000_2000; imm_off = 32'h0000_0010;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (id_stall === 1'b1) stalls++;
            tick();
        end
        opnd_ready = 1'b1; gt_zero = 1'b1;
        #1;
        n_checks++;
        if (id_stall !== 1'b0) $display("FAIL stall_release: got %b want 0", id_stall);
        else n_pass++;
        n_checks++;
        if (stalls != 3) $display("FAIL stall_cycles: got %0d want 3", stalls);
        else n_pass++;
        exp_q.push_back(32'h0000_2040);
        tick();
        idle_inputs();
        n_checks++;
        if (pc_src !== 1'b1) $display("FAIL stall_redirect: got %b want 1", pc_src);
        else n_pass++;
`ifdef BRANCH_STATS_EN
        n_checks++;
        if ({stat_branches, stat_taken, stat_stall_cyc} !== {32'd1, 32'd1, 32'd3})
            $display("FAIL stall_stats: got %0d %0d %0d want 1 1 3",
                     stat_branches, stat_taken, stat_stall_cyc);
        else n_pass++;
`else
        n_checks++;
        if ({stat_branches, stat_taken, stat_stall_cyc} !== 96'd0)
            $display("FAIL stall_stats_off: got %0d %0d %0d want 0 0 0",
                     stat_branches, stat_taken, stat_stall_cyc);
        else n_pass++;
`endif
        tick();
    endtask

    task automatic test_wrap();
        br_valid = 1'b1; br_type = BR_BEQ; equal = 1'b1;
        pc_plus4 = 32'h0000_0000; imm_off = 32'hFFFF_FFFF;
        exp_q.push_back(32'hFFFF_FFFC);
        tick();
        idle_inputs();
        n_checks++;
        if (pc_src !== 1'b1) $display("FAIL wrap_redirect: got %b want 1", pc_src);
        else n_pass++;
        tick();
        n_checks++;
        if (br_target !== 32'hFFFF_FFFC) $display("FAIL wrap_target: got %h want fffffffc", br_target);
        else n_pass++;
    endtask

    task automatic test_ext_stall();
        br_valid = 1'b1; br_type = BR_BEQ; equal = 1'b1; ext_stall = 1'b1;
        pc_plus4 = 32'h0000_3000; imm_off = 32'h1;
        tick();
        n_checks++;
        if (pc_src !== 1'b0) $display("FAIL ext_stall_hold: got %b want 0", pc_src);
        else n_pass++;
        ext_stall = 1'b0;
        exp_q.push_back(32'h0000_3004);
        tick();
        ext_stall = 1'b1;
        br_valid = 1'b0;
        tick();
        n_checks++;
        if ({pc_src, if_id_flush} !== 2'b00)
            $display("FAIL ext_stall_redirect_len: got %b want 00", {pc_src, if_id_flush});
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_timeout();
        do_reset();
        br_valid = 1'b1; br_type = BR_BEQ; opnd_ready = 1'b0;
        pc_plus4 = 32'h0000_4000; imm_off = 32'h2;
        for (int c = 0; c < 15; c++) tick();
        n_checks++;
        if (br_timeout !== 1'b0) $display("FAIL timeout_early: got %b want 0", br_timeout);
        else n_pass++;
        tick();
        n_checks++;
        if (br_timeout !== 1'b1) $display("FAIL timeout_set: got %b want 1", br_timeout);
        else n_pass++;
        opnd_ready = 1'b1; equal = 1'b1;
        exp_q.push_back(32'h0000_4008);
        tick();
        idle_inputs();
        tick();
        tick();
        n_checks++;
        if (br_timeout !== 1'b1) $display("FAIL timeout_sticky: got %b want 1", br_timeout);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (br_timeout !== 1'b0) $display("FAIL timeout_reset: got %b want 0", br_timeout);
        else n_pass++;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        // br_valid held through REDIRECT must not produce a second redirect.
        br_valid = 1'b1; br_type = BR_BNE; not_equal = 1'b1;
        pc_plus4 = 32'h0000_5000; imm_off = 32'h4;
        exp_q.push_back(32'h0000_5010);
        tick();
        tick();
        n_checks++;
        if (pc_src !== 1'b0) $display("FAIL squash_ignored: got %b want 0", pc_src);
        else n_pass++;
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_redirect();
        br_valid = 1'b1; br_type = BR_BEQ; equal = 1'b1;
        pc_plus4 = 32'h0000_6000; imm_off = 32'h1;
        tick();
        n_checks++;
        if (pc_src !== 1'b1) $display("FAIL rst_redirect_pre: got %b want 1", pc_src);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({pc_src, if_id_flush} !== 2'b00)
            $display("FAIL rst_redirect_async: got %b want 00", {pc_src, if_id_flush});
        else n_pass++;
        idle_inputs();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if ({pc_src, if_id_flush, id_stall} !== 3'b000)
                $display("FAIL rst_redirect_after[%0d]: got %b want 000", c,
                         {pc_src, if_id_flush, id_stall});
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_beq();
        test_conditions();
        test_stall();
        test_wrap();
        test_ext_stall();
        test_timeout();
        test_back_to_back();
        test_reset_redirect();
        tick();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL missing_redirects: got %0d pending want 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
